counter_load_arbiter: RTL
=========================

COUNTER_LOAD_ARBITER -- requirements
Module: counter_load_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the counter data width.
REQ-002 SHALL use reset reset, synchronous, active-high; clock clock.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req  input  2  per-requester load request; bit i belongs to requester i.
REQ-006 wdata0  input  DATA_W  load value from requester 0.
REQ-007 wdata1  input  DATA_W  load value from requester 1.
REQ-008 gnt  output  2  one-hot grant; at most one bit high.
REQ-009 done  output  2  one-cycle pulse per requester; its load has been committed.
REQ-010 cnt_we  output  1  write enable to the free-running counter.
REQ-011 cnt_din  output  DATA_W  load value to the counter.
REQ-012 cnt_value  input  DATA_W  current counter output.
REQ-013 wrap_irq  output  1  one-cycle pulse on a natural counter wrap.
REQ-014 wrap_flag  output  1  sticky wrap indicator.
REQ-015 wrap_clr  input  1  clears wrap_flag.

Function
REQ-016 FSM states: IDLE, GRANT, LOAD, ACK.
REQ-017 IDLE -> GRANT on the edge where any req bit is sampled high; the winner's gnt bit goes high and its wdata is latched.
REQ-018 GRANT -> LOAD next edge if the winner's req is still high; otherwise abort to IDLE with no write and no done.
REQ-019 LOAD: cnt_we=1 and cnt_din=latched value for exactly one cycle -> ACK.
REQ-020 ACK: done[winner]=1 for exactly one cycle -> IDLE.
REQ-021 gnt[winner] held high through GRANT, LOAD and ACK; gnt=0 in IDLE.
REQ-022 Latency: req sampled at edge k gives gnt high after edge k, cnt_we high after k+1, done high after k+2, and IDLE after k+3.
REQ-023 Round-robin: a 1-bit priority pointer selects the winner when both req bits are high.
REQ-024 The pointer moves to the non-winner after each completed ACK; it is unchanged on abort.
REQ-025 A single active req wins regardless of the pointer.
REQ-026 A requester SHALL keep req high until its done pulse; a req still high in the IDLE cycle after ACK is treated as a new request.
REQ-027 Latched data SHALL NOT change while outside IDLE, even if wdata changes.
REQ-028 cnt_din SHALL be 0 when cnt_we=0.
REQ-029 wrap_irq pulses when the previous cnt_value was all-ones, the current cnt_value is 0, and cnt_we was 0 in the previous cycle; a load to 0 is not a wrap.
REQ-030 wrap_flag is set by wrap_irq and cleared by wrap_clr; if both occur in the same cycle, set wins.

Reset
REQ-031 Reset SHALL force state=IDLE, pointer=0 (requester 0 preferred), gnt=0, done=0, cnt_we=0, cnt_din=0, wrap_irq=0, wrap_flag=0, and the previous-value register to 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction: no cnt_we and no done afterwards.
REQ-033 Reset has priority over every other input in the same cycle.

Structure
REQ-034 Package counter_pkg SHALL hold DATA_W default, the ctrl_state_t enum (IDLE, GRANT, LOAD, ACK), and the CNT_MAX all-ones constant.
REQ-035 Winner selection and pointer update SHALL reside in sub-module rr_arbiter2; the FSM, data latch and wrap logic stay in the top module.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 req=01 with wdata0=0x5A -> gnt=01 after +1 edge, cnt_we=1 with cnt_din=0x5A after +2, done=01 after +3, and counter reads 0x5B one cycle after the load.
REQ-038 req=11 out of reset -> requester 0 served first, then requester 1 without a gap in IDLE; pointer=0 again after both.
REQ-039 req=10 dropped during GRANT -> no cnt_we, no done, and the pointer is unchanged.
REQ-040 Counter free-runs 0xFE->0xFF->0x00 -> one wrap_irq pulse and wrap_flag=1; wrap_clr=1 -> flag clears.
REQ-041 Load 0x00 while cnt_value=0xFF -> no wrap_irq.
REQ-042 Reset asserted during LOAD -> all outputs 0 the next cycle and state=IDLE.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter load arbiter.
package counter_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [DATA_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOAD,
    ACK
  } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin winner select with a 1-bit priority pointer.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       winner_c
);

  logic ptr;

  // Pointer moves to the requester that was not just served.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

  // A lone request always wins; the pointer only breaks ties.
  always_comb begin
    winner_c = 1'b0;
    case (req)
      2'b01:   winner_c = 1'b0;
      2'b10:   winner_c = 1'b1;
      2'b11:   winner_c = ptr;
      default: winner_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/counter_load_arbiter.sv
// Arbitrates two load requesters onto a free-running counter and flags
// natural counter wraps.
module counter_load_arbiter
  import counter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              cnt_we,
  output logic [DATA_W-1:0] cnt_din,
  input  logic [DATA_W-1:0] cnt_value,
  output logic              wrap_irq,
  output logic              wrap_flag,
  input  logic              wrap_clr
);

  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

  ctrl_state_t       state;
  logic              win_idx;
  logic [DATA_W-1:0] data_q;
  logic              winner_c;
  logic [DATA_W-1:0] prev_value;
  logic              prev_we;

  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .advance  (state == ACK),
    .served   (win_idx),
    .winner_c (winner_c)
  );

  // Load handshake FSM; every output is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      win_idx <= 1'b0;
      data_q  <= '0;
      gnt     <= '0;
      done    <= '0;
      cnt_we  <= 1'b0;
      cnt_din <= '0;
    end else begin
      done    <= '0;
      cnt_we  <= 1'b0;
      cnt_din <= '0;
      case (state)
        IDLE: begin
          gnt <= '0;
          if (|req) begin
            state   <= GRANT;
            win_idx <= winner_c;
            gnt     <= winner_c ? 2'b10 : 2'b01;
            data_q  <= winner_c ? wdata1 : wdata0;
          end
        end
        GRANT: begin
          if (req[win_idx]) begin
            state   <= LOAD;
            cnt_we  <= 1'b1;
            cnt_din <= data_q;
          end else begin
            state <= IDLE;
            gnt   <= '0;
          end
        end
        LOAD: begin
          state         <= ACK;
          done[win_idx] <= 1'b1;
        end
        ACK: begin
          state <= IDLE;
          gnt   <= '0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // Wrap detect: all-ones followed by zero with no load in between.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_value <= '0;
      prev_we    <= 1'b0;
      wrap_irq   <= 1'b0;
      wrap_flag  <= 1'b0;
    end else begin
      prev_value <= cnt_value;
      prev_we    <= cnt_we;
      wrap_irq   <= (prev_value == ALL_ONES) && (cnt_value == '0) && !prev_we;
      if (wrap_irq) begin
        wrap_flag <= 1'b1;
      end else if (wrap_clr) begin
        wrap_flag <= 1'b0;
      end
    end
  end

endmodule
